vga_pixel_serializer: RTL and testbench
=======================================

VGA_PIXEL_SERIALIZER -- requirements
Module: vga_pixel_serializer

Interface
REQ-001 Parameter PIXELS, default 32: pixels per visible line and row-word width; legal values are 8, 16 or 32.
REQ-002 Parameter LSB_FIRST, default 1: 1 = pixel x shown from row bit x; 0 = pixel x shown from bit PIXELS-1-x.
REQ-003 Port clk, input, 1: single clock; all state on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 Port row_data, input, PIXELS: next line's pixel row from the framebuffer.
REQ-006 Port row_valid, input, 1: row_data holds a word.
REQ-007 Port row_ready, output, 1: serializer accepts row_data this cycle.
REQ-008 Port line_start, input, 1: one-cycle pulse before the first visible pixel of a line.
REQ-009 Port pix_tick, input, 1: one-cycle pixel strobe from the pixel divider.
REQ-010 Port blank, input, 1: outside the visible area.
REQ-011 Ports hsync_in, vsync_in, input, 1 each: timing syncs.
REQ-012 Ports fg_rgb, bg_rgb, input, 6 each: RGB222 foreground and background colours.
REQ-013 Port rgb, output, 6: pixel colour as {R1,R0,G1,G0,B1,B0}.
REQ-014 Ports hsync_out, vsync_out, output, 1 each: syncs aligned to rgb.
REQ-015 Port underrun, output, 1: sticky flag for a missed row.
REQ-016 Port clr_underrun, input, 1: clears underrun.

Function
REQ-017 Storage is a shadow register (next row) and an active shift register (current row); each has a full bit, and the active side keeps a remaining-pixel count of clog2(PIXELS)+1 bits.
REQ-018 row_ready = !shadow_full || line_start; a word transfers when row_valid && row_ready.
REQ-019 On line_start with shadow full, the shadow word moves to active, count = PIXELS, and the shadow may accept a new word in the same cycle.
REQ-020 On line_start with shadow empty and row_valid high, row_data loads straight into active (bypass) with count = PIXELS; this is not an underrun.
REQ-021 On line_start with shadow empty and row_valid low, active is cleared, count = 0, and underrun is set.
REQ-022 On pix_tick && !blank && count>0, rgb on the next cycle is fg_rgb if the current bit is 1, else bg_rgb; the register then shifts one pixel and count decrements.
REQ-023 On pix_tick && !blank && count==0, rgb on the next cycle is bg_rgb and no shift occurs.
REQ-024 Whenever blank is high, rgb is 0 on the next cycle and no shift occurs; ticks during blank are ignored.
REQ-025 With no pix_tick, rgb holds its value except under the blank rule.
REQ-026 hsync_out and vsync_out are hsync_in and vsync_in delayed by exactly one clk, giving the same latency as rgb.
REQ-027 If clr_underrun and an underrun event occur in the same cycle, the set wins.
REQ-028 If line_start and pix_tick coincide, the load happens first and the pixel is drawn from the newly loaded row.

Reset
REQ-029 While rst_n is low, all outputs and state are 0: shadow/active empty, count 0, rgb 0, syncs 0, underrun 0; row_ready is 1 in the first cycle after release.
REQ-030 Reset asserted mid-line aborts the line; no partial state survives.

Configuration
REQ-031 Macro VGA_SER_PALETTE_EN is defined: colours come from fg_rgb and bg_rgb as stated above.
REQ-032 Macro VGA_SER_PALETTE_EN is undefined: fg_rgb and bg_rgb are ignored; foreground is 6'b111111 and background is 6'b000000, i.e. a replicated monochrome bit.

Structure
REQ-033 Shared package vga_pkg holds the RGB222 typedef (6 bits), the default PIXELS constant 32, and the colour constants BLACK and WHITE.
REQ-034 The shadow/active double buffer with full flags is the sub-module vga_row_buffer; the count, colour mux and sync alignment stay in the top module.

Verification
REQ-035 Load row 32'h0000_0005, line_start, then 4 pix_ticks, fg=6'h3F, bg=6'h00 -> rgb = 3F, 00, 3F, 00, each one cycle after its tick.
REQ-036 No row_valid before line_start -> underrun = 1 and every tick that line gives bg; clr_underrun -> 0 next cycle.
REQ-037 Row_valid and line_start in the same cycle with shadow empty (bypass) -> no underrun and pixel 0 is correct.
REQ-038 36 ticks after load -> ticks 33 to 36 give bg; blank high -> rgb = 0; hsync_out matches hsync_in delayed 1 cycle throughout.
REQ-039 rst_n low after the 10th pixel -> all outputs 0 at once; the next line with no row loaded flags underrun.
REQ-040 VGA_SER_PALETTE_EN undefined, fg=6'h15 -> a set bit gives rgb = 6'h3F.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA pixel serializer.
package vga_pkg;

  // RGB222 pixel colour laid out as {R1,R0,G1,G0,B1,B0}.
  typedef logic [5:0] rgb222_t;

  localparam int unsigned DEFAULT_PIXELS = 32;

  localparam rgb222_t BLACK = 6'b000000;
  localparam rgb222_t WHITE = 6'b111111;

  // Where the active row comes from on a line_start.
  typedef enum logic [1:0] {
    LOAD_NONE   = 2'd0,  // no line_start: keep the current row
    LOAD_SHADOW = 2'd1,  // shadow word promoted to active
    LOAD_BYPASS = 2'd2,  // row_data written straight into active
    LOAD_EMPTY  = 2'd3   // nothing available: blank row, underrun
  } load_src_e;

  // Width of the remaining-pixel counter (must be able to hold PIXELS).
  function automatic int unsigned count_width(input int unsigned pixels);
    return $clog2(pixels) + 1;
  endfunction

endpackage

// File: rtl/vga_pixel_serializer_if.sv
// Row-word handshake between the framebuffer (master) and the serializer (slave).
interface vga_pixel_serializer_if
  import vga_pkg::*;
#(
  parameter int unsigned PIXELS = DEFAULT_PIXELS
) ();

  logic [PIXELS-1:0] row_data;
  logic              row_valid;
  logic              row_ready;

  modport master (
    output row_data,
    output row_valid,
    input  row_ready
  );

  modport slave (
    input  row_data,
    input  row_valid,
    output row_ready
  );

endinterface

// File: rtl/vga_row_buffer.sv
// Shadow/active double buffer for pixel rows. The shadow word is the next
// line's row; the active word is the row being shifted out. The source word
// for this cycle (after any line_start load) is resolved combinationally so a
// pixel drawn in the same cycle as line_start comes from the new row.
module vga_row_buffer
  import vga_pkg::*;
#(
  parameter int unsigned PIXELS    = DEFAULT_PIXELS,
  parameter int unsigned LSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PIXELS-1:0] row_data,
  input  logic              row_valid,
  output logic              row_ready,
  input  logic              line_start,
  input  logic              shift_en,
  output logic              cur_bit,
  output logic              cur_full,
  output load_src_e         load_src
);

  logic [PIXELS-1:0] shadow_reg;
  logic              shadow_full_reg;
  logic [PIXELS-1:0] active_reg;
  logic              active_full_reg;

  logic [PIXELS-1:0] src_word;
  logic [PIXELS-1:0] shifted_word;

  // Held low during reset so every output reads 0 while rst_n is asserted.
  assign row_ready = rst_n & (~shadow_full_reg | line_start);

  // Resolve which row is current this cycle and where it came from.
  always_comb begin
    load_src = LOAD_NONE;
    src_word = active_reg;
    cur_full = active_full_reg;
    if (line_start) begin
      if (shadow_full_reg) begin
        load_src = LOAD_SHADOW;
        src_word = shadow_reg;
        cur_full = 1'b1;
      end else if (row_valid) begin
        load_src = LOAD_BYPASS;
        src_word = row_data;
        cur_full = 1'b1;
      end else begin
        load_src = LOAD_EMPTY;
        src_word = '0;
        cur_full = 1'b0;
      end
    end
  end

  // Pixel order: LSB-first shows bit 0 first and shifts right.
  assign cur_bit      = (LSB_FIRST != 0) ? src_word[0] : src_word[PIXELS-1];
  assign shifted_word = (LSB_FIRST != 0) ? (src_word >> 1) : (src_word << 1);

  // Active row: take the resolved source word, shifted when a pixel is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_reg      <= '0;
      active_full_reg <= 1'b0;
    end else begin
      active_reg      <= shift_en ? shifted_word : src_word;
      active_full_reg <= cur_full;
    end
  end

  // Shadow row: refilled whenever it is empty, or in the cycle it is promoted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_reg      <= '0;
      shadow_full_reg <= 1'b0;
    end else if (line_start) begin
      // A bypass load consumes row_data into active, so the shadow only
      // refills here when it was the one being promoted.
      if (shadow_full_reg) begin
        if (row_valid) begin
          shadow_reg      <= row_data;
          shadow_full_reg <= 1'b1;
        end else begin
          shadow_full_reg <= 1'b0;
        end
      end
    end else if (row_valid && !shadow_full_reg) begin
      shadow_reg      <= row_data;
      shadow_full_reg <= 1'b1;
    end
  end

endmodule

// File: rtl/vga_pixel_serializer.sv
// VGA pixel serializer: shifts one framebuffer row per visible line out as
// RGB222 pixels, one per pix_tick, with syncs delayed to match the rgb latency.
// Optional feature macro: VGA_SER_PALETTE_EN -- when defined, foreground and
// background colours come from fg_rgb/bg_rgb; otherwise the output is
// monochrome (WHITE on BLACK) and fg_rgb/bg_rgb are ignored.
// PIXELS must be 8, 16 or 32.
module vga_pixel_serializer
  import vga_pkg::*;
#(
  parameter int unsigned PIXELS    = DEFAULT_PIXELS,
  parameter int unsigned LSB_FIRST = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  vga_pixel_serializer_if.slave  row_if,
  input  logic                   line_start,
  input  logic                   pix_tick,
  input  logic                   blank,
  input  logic                   hsync_in,
  input  logic                   vsync_in,
  input  rgb222_t                fg_rgb,
  input  rgb222_t                bg_rgb,
  output rgb222_t                rgb,
  output logic                   hsync_out,
  output logic                   vsync_out,
  output logic                   underrun,
  input  logic                   clr_underrun
);

  localparam int unsigned CW = count_width(PIXELS);

  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_src;
  logic          cur_bit;
  logic          cur_full;
  logic          has_pixel;
  logic          draw;
  logic          shift_en;
  load_src_e     load_src;
  rgb222_t       fg_col;
  rgb222_t       bg_col;
  rgb222_t       rgb_reg;
  logic          hsync_reg;
  logic          vsync_reg;
  logic          underrun_reg;

`ifdef VGA_SER_PALETTE_EN
  assign fg_col = fg_rgb;
  assign bg_col = bg_rgb;
`else
  logic palette_unused;
  assign palette_unused = ^{fg_rgb, bg_rgb};
  assign fg_col = WHITE;
  assign bg_col = BLACK;
`endif

  vga_row_buffer #(
    .PIXELS    (PIXELS),
    .LSB_FIRST (LSB_FIRST)
  ) u_row_buffer (
    .clk        (clk),
    .rst_n      (rst_n),
    .row_data   (row_if.row_data),
    .row_valid  (row_if.row_valid),
    .row_ready  (row_if.row_ready),
    .line_start (line_start),
    .shift_en   (shift_en),
    .cur_bit    (cur_bit),
    .cur_full   (cur_full),
    .load_src   (load_src)
  );

  // Remaining-pixel count as seen after any line_start load this cycle.
  always_comb begin
    count_src = count_reg;
    case (load_src)
      LOAD_SHADOW, LOAD_BYPASS: count_src = CW'(PIXELS);
      LOAD_EMPTY:               count_src = '0;
      default:                  count_src = count_reg;
    endcase
  end

  assign has_pixel = cur_full && (count_src != '0);
  assign draw      = pix_tick && !blank;
  assign shift_en  = draw && has_pixel;

  // Count down one per drawn pixel; reload happens through count_src.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= shift_en ? (count_src - CW'(1)) : count_src;
    end
  end

  // Colour mux: blank forces black, a tick draws fg/bg, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_reg <= BLACK;
    end else if (blank) begin
      rgb_reg <= BLACK;
    end else if (pix_tick) begin
      rgb_reg <= (has_pixel && cur_bit) ? fg_col : bg_col;
    end
  end

  // Delay syncs by one clock so they line up with rgb.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_reg <= 1'b0;
      vsync_reg <= 1'b0;
    end else begin
      hsync_reg <= hsync_in;
      vsync_reg <= vsync_in;
    end
  end

  // Sticky underrun: a missed row on line_start sets it and beats a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun_reg <= 1'b0;
    end else if (load_src == LOAD_EMPTY) begin
      underrun_reg <= 1'b1;
    end else if (clr_underrun) begin
      underrun_reg <= 1'b0;
    end
  end

  assign rgb       = rgb_reg;
  assign hsync_out = hsync_reg;
  assign vsync_out = vsync_reg;
  assign underrun  = underrun_reg;

endmodule

// File: tb/tb_vga_pixel_serializer.sv
// Directed, table-driven bench for vga_pixel_serializer (PIXELS=32, LSB first).
module tb_vga_pixel_serializer;
  import vga_pkg::*;

  localparam int S_ZERO = 0;
  localparam int S_FG   = 1;
  localparam int S_BG   = 2;

  typedef struct {
    logic        rv;
    logic [31:0] data;
    logic        ls;
    logic        tick;
    logic        blk;
    logic        hs;
    logic        vs;
    logic        clr;
    rgb222_t     fg;
    rgb222_t     bg;
    logic        rdy;
    int          sel;
    logic        ur;
  } vec_t;

  logic    clk = 1'b0;
  logic    rst_n;
  logic    line_start, pix_tick, blank, hsync_in, vsync_in, clr_underrun;
  rgb222_t fg_rgb, bg_rgb, rgb;
  logic    hsync_out, vsync_out, underrun;

  int n_vec = 0;
  int n_bad = 0;

  vga_pixel_serializer_if #(.PIXELS(32)) row_if ();

  vga_pixel_serializer #(.PIXELS(32), .LSB_FIRST(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .row_if       (row_if),
    .line_start   (line_start),
    .pix_tick     (pix_tick),
    .blank        (blank),
    .hsync_in     (hsync_in),
    .vsync_in     (vsync_in),
    .fg_rgb       (fg_rgb),
    .bg_rgb       (bg_rgb),
    .rgb          (rgb),
    .hsync_out    (hsync_out),
    .vsync_out    (vsync_out),
    .underrun     (underrun),
    .clr_underrun (clr_underrun)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rv, input logic [31:0] d, input logic ls,
                              input logic tick, input logic blk, input logic hs,
                              input logic vs, input logic clr, input rgb222_t fg,
                              input rgb222_t bg, input logic rdy, input int sel,
                              input logic ur);
    vec_t v;
    v.rv = rv; v.data = d; v.ls = ls; v.tick = tick; v.blk = blk; v.hs = hs;
    v.vs = vs; v.clr = clr; v.fg = fg; v.bg = bg; v.rdy = rdy; v.sel = sel; v.ur = ur;
    return v;
  endfunction

  // Expected colour for a selector; the monochrome build ignores fg/bg.
  function automatic rgb222_t col(input int sel, input rgb222_t fg, input rgb222_t bg);
`ifdef VGA_SER_PALETTE_EN
    if (sel == S_FG) return fg;
    if (sel == S_BG) return bg;
    return BLACK;
`else
    if (sel == S_FG) return WHITE;
    return BLACK;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one vector, check row_ready before the edge and registered outputs after it.
  task automatic apply(input vec_t v, input string tag);
    row_if.row_valid = v.rv;
    row_if.row_data  = v.data;
    line_start       = v.ls;
    pix_tick         = v.tick;
    blank            = v.blk;
    hsync_in         = v.hs;
    vsync_in         = v.vs;
    clr_underrun     = v.clr;
    fg_rgb           = v.fg;
    bg_rgb           = v.bg;
    #1;
    check({tag, " row_ready"}, 32'(row_if.row_ready), 32'(v.rdy));
    @(posedge clk);
    #1;
    check({tag, " rgb"}, 32'(rgb), 32'(col(v.sel, v.fg, v.bg)));
    check({tag, " hsync_out"}, 32'(hsync_out), 32'(v.hs));
    check({tag, " vsync_out"}, 32'(vsync_out), 32'(v.vs));
    check({tag, " underrun"}, 32'(underrun), 32'(v.ur));
    $display("vec %s rgb=%02h hs=%b vs=%b ur=%b", tag, rgb, hsync_out, vsync_out, underrun);
  endtask

  vec_t vecs[15];
  vec_t v;

  initial begin
    // Main line: row 5, then palette colours, shadow-full back-pressure, coincident load.
    //              rv  data          ls tk bk hs vs clr fg     bg     rdy sel     ur
    vecs[0]  = mk(1, 32'h0000_0005, 0, 0, 0, 1, 0, 0, 6'h3F, 6'h00, 1, S_ZERO, 0);
    vecs[1]  = mk(0, 32'h0,         1, 0, 0, 0, 1, 0, 6'h3F, 6'h00, 1, S_ZERO, 0);
    vecs[2]  = mk(0, 32'h0,         0, 1, 0, 1, 1, 0, 6'h3F, 6'h00, 1, S_FG,   0);
    vecs[3]  = mk(0, 32'h0,         0, 1, 0, 0, 0, 0, 6'h3F, 6'h00, 1, S_BG,   0);
    vecs[4]  = mk(0, 32'h0,         0, 1, 0, 1, 0, 0, 6'h3F, 6'h00, 1, S_FG,   0);
    vecs[5]  = mk(0, 32'h0,         0, 1, 0, 0, 1, 0, 6'h3F, 6'h00, 1, S_BG,   0);
    vecs[6]  = mk(0, 32'h0,         0, 0, 0, 1, 1, 0, 6'h3F, 6'h00, 1, S_BG,   0);
    vecs[7]  = mk(0, 32'h0,         0, 1, 1, 0, 0, 0, 6'h3F, 6'h00, 1, S_ZERO, 0);
    vecs[8]  = mk(0, 32'h0,         0, 1, 0, 1, 0, 0, 6'h15, 6'h2A, 1, S_BG,   0);
    vecs[9]  = mk(1, 32'h0000_0003, 0, 0, 0, 0, 1, 0, 6'h15, 6'h2A, 1, S_BG,   0);
    vecs[10] = mk(1, 32'hFFFF_FFFF, 0, 0, 0, 1, 1, 0, 6'h15, 6'h2A, 0, S_BG,   0);
    vecs[11] = mk(0, 32'h0,         1, 1, 0, 0, 0, 0, 6'h15, 6'h2A, 1, S_FG,   0);
    vecs[12] = mk(0, 32'h0,         0, 1, 0, 1, 0, 0, 6'h15, 6'h2A, 1, S_FG,   0);
    vecs[13] = mk(0, 32'h0,         0, 0, 1, 0, 1, 0, 6'h15, 6'h2A, 1, S_ZERO, 0);
    vecs[14] = mk(0, 32'h0,         0, 1, 0, 1, 1, 0, 6'h15, 6'h2A, 1, S_BG,   0);

    // Reset state.
    rst_n = 1'b0;
    row_if.row_valid = 1'b0; row_if.row_data = '0;
    line_start = 0; pix_tick = 0; blank = 0; hsync_in = 1; vsync_in = 1;
    clr_underrun = 0; fg_rgb = 6'h3F; bg_rgb = 6'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset rgb", 32'(rgb), 32'(0));
    check("reset hsync_out", 32'(hsync_out), 32'(0));
    check("reset vsync_out", 32'(vsync_out), 32'(0));
    check("reset underrun", 32'(underrun), 32'(0));
    check("reset row_ready", 32'(row_if.row_ready), 32'(0));
    rst_n = 1'b1;
    hsync_in = 0; vsync_in = 0;
    #1;
    check("post-reset row_ready", 32'(row_if.row_ready), 32'(1));
    @(posedge clk);
    #1;

    for (int i = 0; i < 15; i++) apply(vecs[i], $sformatf("tbl%0d", i));

    // Underrun: no row before line_start, ticks give bg, clear, set beats clear.
    apply(mk(0, 32'h0, 1, 0, 0, 0, 0, 0, 6'h15, 6'h2A, 1, S_BG, 1), "ur_ls");
    for (int i = 0; i < 3; i++)
      apply(mk(0, 32'h0, 0, 1, 0, i[0], 0, 0, 6'h15, 6'h2A, 1, S_BG, 1), $sformatf("ur_tick%0d", i));
    apply(mk(0, 32'h0, 0, 0, 0, 0, 1, 1, 6'h15, 6'h2A, 1, S_BG, 0), "ur_clr");
    apply(mk(0, 32'h0, 1, 0, 0, 1, 0, 1, 6'h15, 6'h2A, 1, S_BG, 1), "ur_set_wins");
    apply(mk(0, 32'h0, 0, 0, 0, 0, 0, 1, 6'h15, 6'h2A, 1, S_BG, 0), "ur_clr2");

    // Bypass: row_valid with line_start and a coincident tick, shadow empty.
    apply(mk(1, 32'h0000_0009, 1, 1, 0, 1, 1, 0, 6'h15, 6'h2A, 1, S_FG, 0), "byp_p0");
    apply(mk(0, 32'h0, 0, 1, 0, 0, 1, 0, 6'h15, 6'h2A, 1, S_BG, 0), "byp_p1");
    apply(mk(0, 32'h0, 0, 1, 0, 1, 0, 0, 6'h15, 6'h2A, 1, S_BG, 0), "byp_p2");
    apply(mk(0, 32'h0, 0, 1, 0, 0, 0, 0, 6'h15, 6'h2A, 1, S_FG, 0), "byp_p3");

    // 36 ticks on an all-ones row: pixels 33..36 fall back to bg.
    apply(mk(1, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 6'h15, 6'h2A, 1, S_FG, 0), "long_load");
    apply(mk(0, 32'h0, 1, 0, 0, 1, 0, 0, 6'h15, 6'h2A, 1, S_FG, 0), "long_ls");
    for (int i = 1; i <= 36; i++)
      apply(mk(0, 32'h0, 0, 1, 0, (i % 3) == 0, (i % 5) == 0, 0, 6'h15, 6'h2A, 1,
               (i <= 32) ? S_FG : S_BG, 0), $sformatf("long_t%0d", i));
    apply(mk(0, 32'h0, 0, 1, 1, 1, 1, 0, 6'h15, 6'h2A, 1, S_ZERO, 0), "long_blank");

    // Reset mid-line after the 10th pixel, with underrun and syncs high.
    apply(mk(0, 32'h0, 1, 0, 0, 0, 0, 0, 6'h15, 6'h2A, 1, S_ZERO, 1), "rst_ur");
    apply(mk(1, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 6'h15, 6'h2A, 1, S_ZERO, 1), "rst_load");
    apply(mk(0, 32'h0, 1, 0, 0, 1, 1, 0, 6'h15, 6'h2A, 1, S_ZERO, 1), "rst_ls");
    for (int i = 1; i <= 10; i++)
      apply(mk(0, 32'h0, 0, 1, 0, 1, 1, 0, 6'h15, 6'h2A, 1, S_FG, 1), $sformatf("rst_t%0d", i));
    pix_tick = 0;
    rst_n = 1'b0;
    #1;
    check("midrst rgb", 32'(rgb), 32'(0));
    check("midrst hsync_out", 32'(hsync_out), 32'(0));
    check("midrst vsync_out", 32'(vsync_out), 32'(0));
    check("midrst underrun", 32'(underrun), 32'(0));
    check("midrst row_ready", 32'(row_if.row_ready), 32'(0));
    $display("vec midrst rgb=%02h hs=%b vs=%b ur=%b", rgb, hsync_out, vsync_out, underrun);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("midrst release row_ready", 32'(row_if.row_ready), 32'(1));
    apply(mk(0, 32'h0, 1, 1, 0, 0, 0, 0, 6'h15, 6'h2A, 1, S_BG, 1), "after_rst_ls");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
